// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller for the MEM pipeline stage.
// Turns byte/half/word load and store requests into word-wide memory phases.
// Sub-word stores use a read-modify-write pair; each memory phase is bounded
// by a timeout and aborts with an error.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req, we, size, uns  request, store select, access size, load zero-extend
//   addr, wdata         byte address, right-aligned store data
//   rdata               extended load result (held until the next completed load)
//   done, err           one-cycle completion pulse, error flag valid with done
//   stall               pipeline freeze
//   mem_cs, mem_we      memory select and write enable
//   mem_addr, mem_wdata word-aligned address, full write word
//   mem_rdata, mem_ready read word, phase complete
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [31:0]    buf_q, buf_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mem_cs_q, mem_cs_d;
  logic           mem_we_q, mem_we_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [CW-1:0]  cnt_inc;
  logic           timed_out;
  logic           bad_req;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    load_ext;
  logic [31:0]    buf_merge;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      mem_cs_q <= mem_cs_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    cnt_inc   = cnt_q + CW'(1);
    timed_out = (cnt_inc == CW'(TIMEOUT));
    bad_req   = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);

    // Little-endian lane extraction with optional sign extension
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = mem_rdata;
    endcase

    // Read word with the addressed lane replaced by the store data
    buf_merge = mem_rdata;
    if (size_q[0]) buf_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else           buf_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          uns_d   = uns;
          wdata_d = wdata[15:0];
          cnt_d   = '0;
          if (bad_req) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (!we) begin
            state_d = RD;
          end else if (size == 2'b10) begin
            state_d = WR;
            buf_d   = wdata;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        if (mem_ready) begin
          rdata_d = load_ext;
          state_d = RESP;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = RESP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RMW_RD: begin
        if (mem_ready) begin
          buf_d   = buf_merge;
          state_d = WR;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = RESP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR: begin
        if (mem_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = RESP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory strobes and done track the state being entered
    mem_cs_d = (state_d == RD) || (state_d == RMW_RD) || (state_d == WR);
    mem_we_d = (state_d == WR);
    done_d   = (state_d == RESP);
  end

  // Stall must see req in IDLE the same cycle; reset forces it low
  assign stall = rst_n && (((state_q == IDLE) && req) ||
                           (state_q == RD) || (state_q == RMW_RD) || (state_q == WR));

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = buf_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        done, err, stall;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  int          cyc;
  logic [31:0] wword, waddr;
  logic        cs_seen, err_seen, done_any;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .we(we), .size(size), .uns(uns), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .stall(stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and follow it to done (bounded wait)
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                        output int n, output logic [31:0] ww, output logic [31:0] wa,
                        output logic cs, output logic e);
    we = w; size = sz; uns = u; addr = a; wdata = wd; mem_ready = rdy; req = 1'b1;
    n = 1; ww = '0; wa = '0; cs = 1'b0; e = 1'b0;
    #1;
    chk("stall_idle_req", 32'(stall), 32'd1);
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (mem_cs) cs = 1'b1;
      if (mem_cs && mem_we) begin
        ww = mem_wdata;
        wa = mem_addr;
      end
      if (done) begin
        e = err;
        break;
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("stall_resp", 32'(stall), 32'd0);
    chk("cs_resp", 32'(mem_cs), 32'd0);
    req = 1'b0;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("err_after_done", 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Loads, ready held high (also while idle)
    mem_rdata = 32'h80FF_1234;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_cycles", 32'(cyc), 32'd3);
    chk("lb_err", 32'(err_seen), 32'd0);

    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lhu_rdata", rdata, 32'h0000_80FF);
    chk("lhu_cycles", 32'(cyc), 32'd3);

    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lh_rdata", rdata, 32'hFFFF_80FF);

    do_req(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lbu_rdata", rdata, 32'h0000_00FF);

    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lb1_rdata", rdata, 32'h0000_0012);

    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lw_rdata", rdata, 32'h80FF_1234);
    chk("lw_cycles", 32'(cyc), 32'd3);

    // Stores
    mem_rdata = 32'h1122_3344;
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AA, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("sb_wword", wword, 32'h1122_AA44);
    chk("sb_waddr", waddr, 32'h0000_0100);
    chk("sb_cycles", 32'(cyc), 32'd4);
    chk("sb_err", 32'(err_seen), 32'd0);
    chk("sb_rdata_hold", rdata, 32'h80FF_1234);

    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hCAFE_BEEF, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("sh_wword", wword, 32'hBEEF_3344);
    chk("sh_cycles", 32'(cyc), 32'd4);

    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("sw_wword", wword, 32'hDEAD_BEEF);
    chk("sw_waddr", waddr, 32'h0000_0104);
    chk("sw_cycles", 32'(cyc), 32'd3);

    // Errors: no memory access, rdata untouched
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("lw_mis_err", 32'(err_seen), 32'd1);
    chk("lw_mis_cycles", 32'(cyc), 32'd2);
    chk("lw_mis_cs", 32'(cs_seen), 32'd0);
    chk("lw_mis_rdata", rdata, 32'h80FF_1234);

    do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("sh_mis_err", 32'(err_seen), 32'd1);
    chk("sh_mis_cs", 32'(cs_seen), 32'd0);

    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("size11_err", 32'(err_seen), 32'd1);

    // Word store timeout: one IDLE cycle, 16 WR cycles, then RESP
    do_req(1'b1, 2'b10, 1'b0, 32'h108, 32'h1234_5678, 1'b0, cyc, wword, waddr, cs_seen, err_seen);
    chk("to_err", 32'(err_seen), 32'd1);
    chk("to_cycles", 32'(cyc), 32'd18);
    chk("to_stall_after", 32'(stall), 32'd0);
    chk("to_cs_after", 32'(mem_cs), 32'd0);

    // Reset during RMW_RD
    we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h101; wdata = 32'hAA;
    mem_ready = 1'b0; req = 1'b1;
    tick();
    chk("rmw_cs", 32'(mem_cs), 32'd1);
    chk("rmw_we", 32'(mem_we), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs", 32'(mem_cs), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    req = 1'b0;
    done_any = 1'b0;
    tick();
    if (done) done_any = 1'b1;
    tick();
    if (done) done_any = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_any = 1'b1;
    end
    chk("rst_mid_no_done", 32'(done_any), 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);

    mem_rdata = 32'h0BAD_F00D;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, cyc, wword, waddr, cs_seen, err_seen);
    chk("post_rst_lw_rdata", rdata, 32'h0BAD_F00D);
    chk("post_rst_lw_cycles", 32'(cyc), 32'd3);
    chk("post_rst_lw_err", 32'(err_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
REQ-002 The block SHALL have this parameter:
- TIMEOUT, default 16, maximum cycles to wait for mem_ready in one memory phase before aborting.
REQ-003 The block SHALL have these pipeline-side ports:
- req  in  1  MEM-stage access request, held stable until done
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- uns  in  1  load zero-extend (lbu/lhu)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load result
- done  out  1  one-cycle completion pulse
- err  out  1  misalign, illegal size or timeout; valid with done
- stall  out  1  freeze pipeline
REQ-004 The block SHALL have these memory-side ports:
- mem_cs  out  1  memory select
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read word
- mem_ready  in  1  phase complete

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, RD, RMW_RD, WR, RESP.
REQ-006 In IDLE with req=1, the block SHALL latch addr, we, size, uns and wdata, clear the timeout counter, and branch as follows:
- error (size=11, half with addr[0]=1, or word with addr[1:0]!=0) -> RESP with err=1 and no memory access
- load -> RD
- word store -> WR, with buffer=wdata
- byte/half store -> RMW_RD
REQ-007 In RD and RMW_RD, the block SHALL drive mem_cs=1 and mem_we=0.
REQ-008 In WR, the block SHALL drive mem_cs=1, mem_we=1 and mem_wdata=buffer.
REQ-009 In every other state, the block SHALL drive mem_cs=0 and mem_we=0.
REQ-010 In RD with mem_ready=1, the block SHALL register rdata from little-endian lane extraction and go to RESP:
- byte lane = addr[1:0]
- half lane = addr[1]
- word = the full read word
- the lane value is sign-extended when uns=0 and zero-extended when uns=1.
REQ-011 In RMW_RD with mem_ready=1, the block SHALL load buffer=mem_rdata with the addressed byte/half lane replaced by wdata[7:0]/wdata[15:0], and go to WR.
REQ-012 In WR with mem_ready=1, the block SHALL go to RESP.
REQ-013 In RESP, the block SHALL assert done=1 for exactly one cycle, ignore req, and return to IDLE.
REQ-014 A new request SHALL be accepted only in IDLE, so that back-to-back requests each see one IDLE cycle between them.
REQ-015 The block SHALL drive stall=1 when (state==IDLE and req=1) or state is RD, RMW_RD or WR, and stall=0 otherwise, including in RESP.
REQ-016 The timeout counter SHALL increment each cycle in RD, RMW_RD or WR while mem_ready=0, and SHALL clear on each phase change.
- When it reaches TIMEOUT, the block SHALL go to RESP with err=1 and drop mem_cs the next cycle; no write occurs after a timeout in RMW_RD.
REQ-017 err SHALL be registered, and held valid only while done=1; otherwise it reads 0.
REQ-018 rdata SHALL hold its value until the next completed load; stores and errors SHALL leave rdata unchanged.
REQ-019 Latency with mem_ready asserted in the first phase cycle SHALL be:
- aligned load: 3 cycles from req to done
- word store: 3 cycles
- sub-word store: 4 cycles
- error: 2 cycles
REQ-020 If mem_ready is asserted in IDLE or RESP, the block SHALL ignore it.

Reset
REQ-021 While rst_n=0, the block SHALL immediately force:
- state = IDLE
- mem_cs, mem_we, done, err and stall = 0
- rdata, buffer, mem_wdata and the counter = 0
REQ-022 Reset asserted mid-operation SHALL abort the access with no done pulse, and the block SHALL restart in IDLE after release.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- lb, addr=0x103, mem_rdata=0x80FF_1234, ready immediate -> rdata=0xFFFF_FF80, done at cycle 3, err=0.
- lhu, addr=0x102, same mem_rdata -> rdata=0x0000_80FF.
- sb, addr=0x101, wdata=0xAA, mem_rdata=0x1122_3344 -> mem_wdata=0x1122_AA44 in WR, done at cycle 4.
- lw, addr=0x102 -> err=1 with done at cycle 2; mem_cs never asserted.
- sw with mem_ready held 0, TIMEOUT=16 -> err=1 after 16 WR cycles, stall then drops.
- rst_n pulsed low during RMW_RD -> mem_cs=0 at once, no done, next lw completes normally.
